// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   arb_state_e : arbiter FSM states
//   MAX_MASTERS : largest supported number of requesting masters
//   owner_idx_t : owner index wide enough for MAX_MASTERS
package bus_arbiter_pkg;

    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned MAX_OWNER_W = $clog2(MAX_MASTERS);

    typedef logic [MAX_OWNER_W-1:0] owner_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_BEGIN,
        BUSY,
        ABORT
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req        : per-master request vector
//   last_owner : most recently granted master (lowest priority)
//   valid      : at least one request is set
//   pick       : first requesting master after last_owner, wrapping
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned OWNER_W     = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [OWNER_W-1:0]     last_owner,
    output logic                   valid,
    output logic [OWNER_W-1:0]     pick
);

    logic [2*NUM_MASTERS-1:0] doubled;
    logic [NUM_MASTERS-1:0]   rotated;

    // Rotating the request vector so that bit 0 is last_owner+1 turns the
    // wrap-around search into a plain lowest-set-bit search.
    always_comb begin
        doubled = {req, req} >> (32'(last_owner) + 32'd1);
        rotated = doubled[NUM_MASTERS-1:0];
        valid   = 1'b0;
        pick    = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!valid && rotated[i]) begin
                valid = 1'b1;
                pick  = OWNER_W'((32'(last_owner) + 32'd1 + i) % NUM_MASTERS);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared burst bus.
// Grants one master at a time and tracks ownership until the owner's end
// strobe or a bus error.
//   clock              : system clock, rising edge
//   reset              : asynchronous, active-low reset
//   requestTransaction : per-master level requests
//   transactionGranted : one-hot, single-cycle grant pulse
//   beginTransactionIn : begin strobe from the current owner
//   endTransactionIn   : end strobe
//   busErrorIn         : slave bus error
//   busOwner           : index of the current or most recent owner
//   busActive          : high from grant cycle through end of transaction
//   endTransactionOut  : forced end strobe (watchdog abort)
//   busErrorOut        : forced error strobe (watchdog abort)
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to enable the watchdog,
// which aborts a transaction left in WAIT_BEGIN/BUSY for TIMEOUT_CYCLES.
module bus_arbiter_rr
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned OWNER_W        = $clog2(NUM_MASTERS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] requestTransaction,
    output logic [NUM_MASTERS-1:0] transactionGranted,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    input  logic                   busErrorIn,
    output logic [OWNER_W-1:0]     busOwner,
    output logic                   busActive,
    output logic                   endTransactionOut,
    output logic                   busErrorOut
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("bus_arbiter_rr: unsupported NUM_MASTERS or TIMEOUT_CYCLES");
    end

    arb_state_e         state_q, state_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] last_q, last_d;
    logic               arm_q, arm_d;
    logic               pick_valid;
    logic [OWNER_W-1:0] pick_idx;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .OWNER_W     (OWNER_W)
    ) u_pick (
        .req        (requestTransaction),
        .last_owner (last_q),
        .valid      (pick_valid),
        .pick       (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        // arm_q stays low for the first edge after reset release so that
        // edge never issues a grant.
        arm_d   = 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (arm_q && pick_valid) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                end
            end
            GRANT: begin
                state_d = WAIT_BEGIN;
`ifdef BUS_ARBITER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_BEGIN: begin
                // Begin together with end is a zero-length transaction.
                if (busErrorIn || (beginTransactionIn && endTransactionIn)) begin
                    state_d = IDLE;
                end else if (beginTransactionIn) begin
                    state_d = BUSY;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (!requestTransaction[owner_q]) begin
                    state_d = IDLE;
`ifdef BUS_ARBITER_TIMEOUT_EN
                end else if (timeout) begin
                    state_d = ABORT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            BUSY: begin
                if (endTransactionIn || busErrorIn) begin
                    state_d = IDLE;
`ifdef BUS_ARBITER_TIMEOUT_EN
                end else if (timeout) begin
                    state_d = ABORT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OWNER_W'(NUM_MASTERS - 1);
            arm_q   <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            arm_q   <= arm_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busOwner           = owner_q;
    assign busActive          = (state_q != IDLE);
    assign transactionGranted = (state_q == GRANT) ? (NUM_MASTERS'(1) << owner_q) : '0;

`ifdef BUS_ARBITER_TIMEOUT_EN
    assign endTransactionOut = (state_q == ABORT);
    assign busErrorOut       = (state_q == ABORT);
`else
    assign endTransactionOut = 1'b0;
    assign busErrorOut       = 1'b0;
`endif

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter for the shared burst bus.
- Sits directly upstream of the DMA custom-instruction masters: it consumes their requestTransaction lines and produces their transactionGranted pulses.
- Tracks bus ownership from grant until the owner's endTransaction or busError, so at most one master drives the bus at a time.
- An optional watchdog aborts hung transactions.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 256, watchdog limit in cycles. Used only with BUS_ARBITER_TIMEOUT_EN.
- OWNER_W, $clog2(NUM_MASTERS), owner index width (derived).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- requestTransaction  in  NUM_MASTERS  per-master level request. Held until granted.
- transactionGranted  out  NUM_MASTERS  one-hot, single-cycle grant pulse.
- beginTransactionIn  in  1  shared bus begin strobe from the current owner.
- endTransactionIn  in  1  shared bus end strobe.
- busErrorIn  in  1  shared bus error from a slave.
- busOwner  out  OWNER_W  index of the current or most recent owner.
- busActive  out  1  high from grant cycle through end of transaction.
- endTransactionOut  out  1  forced end strobe (watchdog only).
- busErrorOut  out  1  forced error strobe (watchdog only).

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - state=IDLE; transactionGranted=0; busActive=0; busOwner=0.
  - endTransactionOut=0; busErrorOut=0.
  - lastOwner=NUM_MASTERS-1, so master 0 has first priority.
  - Watchdog counter=0.
  - Asserting reset mid-transaction drops all outputs the same way. No grant is issued in the first edge after reset release.
- States: IDLE, GRANT, WAIT_BEGIN, BUSY, ABORT.
- IDLE:
  - If any request bit is set at edge k: pick the first set bit searching lastOwner+1, wrapping modulo NUM_MASTERS.
  - Set busOwner=pick and lastOwner=pick; go to GRANT.
  - transactionGranted[pick]=1 and busActive=1 during cycle k+1.
- GRANT: lasts exactly 1 cycle, then go to WAIT_BEGIN. Grant pulse width is exactly one cycle.
- WAIT_BEGIN:
  - beginTransactionIn -> BUSY.
  - If the owner's request falls before begin -> IDLE, abandoning the grant with no error.
  - busErrorIn -> IDLE.
- BUSY:
  - endTransactionIn or busErrorIn -> IDLE.
  - busActive falls on the cycle after end is sampled. The earliest next grant is 2 cycles after the end cycle.
- Simultaneous begin and end in WAIT_BEGIN: treat as a zero-length transaction -> IDLE.
- Requests from non-owners are ignored while not IDLE. There is no preemption.
- Fairness: the master just served has lowest priority in the next arbitration.
- Unrelated begin/end strobes while IDLE are ignored.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - The counter clears on entry to WAIT_BEGIN and to BUSY, and increments every cycle in those states.
  - When the count reaches TIMEOUT_CYCLES-1 -> ABORT.
  - ABORT lasts 1 cycle: endTransactionOut=1, busErrorOut=1, busActive=1. Then go to IDLE.
  - A genuine end/error arriving in the same cycle as the timeout takes precedence, so no ABORT occurs.
- Without the macro:
  - No counter and no ABORT state.
  - endTransactionOut and busErrorOut are tied to 0.
  - WAIT_BEGIN and BUSY wait indefinitely.

Decomposition:
- Shared package bus_arbiter_pkg: state enum (IDLE/GRANT/WAIT_BEGIN/BUSY/ABORT), MAX_MASTERS=8 constant, and an owner index typedef.
- One sub-module, rr_pick: combinational round-robin selector (request vector, lastOwner -> valid, index).
- The FSM, registers and watchdog stay in the top module.

Test Plan:
- Single master: request=4'b0001 after reset -> transactionGranted=4'b0001 for exactly one cycle, one cycle after request is sampled; busOwner=0. Then begin, then end after 5 cycles -> busActive low on the next cycle.
- Contention: request=4'b0110 held -> grant 4'b0010 first. After its end, grant 4'b0100. With 4'b0110 still held, the next grant is 4'b0010 again.
- Wrap-around: owner 3 finishes while request=4'b1001 -> next grant 4'b0001.
- Error and abandon:
  - busErrorIn in BUSY -> IDLE; a new grant is possible 2 cycles later.
  - Owner drops its request in WAIT_BEGIN -> IDLE, with no endTransactionOut.
- Reset mid-BUSY: reset=0 -> busActive=0 and transactionGranted=0 immediately, without waiting for a clock edge. After release, master 0 wins when requests=4'b1111.
- Watchdog (macro defined, TIMEOUT_CYCLES=16): begin then no end -> endTransactionOut=busErrorOut=1 for one cycle, 16 cycles after BUSY entry; then IDLE. Without the macro, the arbiter stays in BUSY.
